// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register with a skid buffer.
// The main register drives the output; the skid register catches one extra
// entry so In_Ready can be a pure register with no path from Out_Ready.
//
// Ports:
//   Clock, Reset_n          rising-edge clock, async active-low reset
//   Flush                   synchronous kill of held and incoming entries
//   In_Valid/In_Ready       upstream handshake (In_Ready registered)
//   In_Ctrl/In_Data         upstream control and data fields
//   Out_Valid/Out_Ready     downstream handshake
//   Out_Ctrl/Out_Data       presented entry (Out_Ctrl = CTRL_BUBBLE when idle)
//   Occupancy               entries held (0..2)
//   StallCount              saturating count of back-pressured cycles
module pipe_stage_reg #(
    parameter int unsigned       DATA_W      = 96,
    parameter int unsigned       CTRL_W      = 8,
    parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy,
    output logic [15:0]       StallCount
);

    localparam int unsigned STALL_W = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    logic               main_valid;
    logic [CTRL_W-1:0]  main_ctrl;
    logic [DATA_W-1:0]  main_data;
    logic               skid_valid;
    logic [CTRL_W-1:0]  skid_ctrl;
    logic [DATA_W-1:0]  skid_data;
    logic               in_ready_q;
    logic [STALL_W-1:0] stall_q;

    logic accept;
    logic drain;

    // Handshakes use only registered state on our side.
    assign accept = In_Valid & in_ready_q;
    assign drain  = main_valid & Out_Ready;

    // All outputs come straight from registers.
    assign In_Ready   = in_ready_q;
    assign Out_Valid  = main_valid;
    assign Out_Ctrl   = main_ctrl;
    assign Out_Data   = main_data;
    assign Occupancy  = 2'(state);
    assign StallCount = stall_q;

    // Stage state machine; main_ctrl is forced to CTRL_BUBBLE whenever main empties,
    // main_data is left alone so the data bus does not toggle on bubbles.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            main_ctrl  <= CTRL_BUBBLE;
            main_data  <= '0;
            skid_valid <= 1'b0;
            skid_ctrl  <= '0;
            skid_data  <= '0;
            in_ready_q <= 1'b0;
            stall_q    <= '0;
        end else begin
            // Back-pressure counter is independent of Flush.
            if (main_valid && !Out_Ready && (stall_q != STALL_MAX)) begin
                stall_q <= stall_q + STALL_W'(1);
            end

            if (Flush) begin
                // A same-cycle drain has already been delivered; accepts are lost.
                state      <= EMPTY;
                main_valid <= 1'b0;
                main_ctrl  <= CTRL_BUBBLE;
                skid_valid <= 1'b0;
                in_ready_q <= 1'b1;
            end else begin
                case (state)
                    EMPTY: begin
                        // First edge after reset raises In_Ready here.
                        in_ready_q <= 1'b1;
                        if (accept) begin
                            state      <= ONE;
                            main_valid <= 1'b1;
                            main_ctrl  <= In_Ctrl;
                            main_data  <= In_Data;
                        end
                    end
                    ONE: begin
                        if (accept && drain) begin
                            main_ctrl <= In_Ctrl;
                            main_data <= In_Data;
                        end else if (accept) begin
                            state      <= FULL;
                            skid_valid <= 1'b1;
                            skid_ctrl  <= In_Ctrl;
                            skid_data  <= In_Data;
                            in_ready_q <= 1'b0;
                        end else if (drain) begin
                            state      <= EMPTY;
                            main_valid <= 1'b0;
                            main_ctrl  <= CTRL_BUBBLE;
                        end
                    end
                    FULL: begin
                        // In_Ready is low here, so only a drain can happen.
                        if (drain) begin
                            state      <= ONE;
                            main_ctrl  <= skid_ctrl;
                            main_data  <= skid_data;
                            skid_valid <= 1'b0;
                            in_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= EMPTY;
                        main_valid <= 1'b0;
                        main_ctrl  <= CTRL_BUBBLE;
                        skid_valid <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed vector table, saturation,
// async reset, and randomized traffic against a queue-based reference model.
// A second instance with DATA_W=1, CTRL_W=1 shares the control stimulus.
module tb_pipe_stage_reg;

    logic        Clock;
    logic        Reset_n;
    logic        Flush;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  in_ctrl;
    logic [95:0] in_data;

    logic        w_in_ready, w_out_valid;
    logic [7:0]  w_out_ctrl;
    logic [95:0] w_out_data;
    logic [1:0]  w_occ;
    logic [15:0] w_stall;

    logic        n_in_ready, n_out_valid;
    logic [0:0]  n_out_ctrl;
    logic [0:0]  n_out_data;
    logic [1:0]  n_occ;
    logic [15:0] n_stall;

    int errors = 0;
    int checks = 0;

    pipe_stage_reg dut_w (
        .Clock(Clock), .Reset_n(Reset_n), .Flush(Flush),
        .In_Valid(in_valid), .In_Ready(w_in_ready),
        .In_Ctrl(in_ctrl), .In_Data(in_data),
        .Out_Valid(w_out_valid), .Out_Ready(out_ready),
        .Out_Ctrl(w_out_ctrl), .Out_Data(w_out_data),
        .Occupancy(w_occ), .StallCount(w_stall)
    );

    pipe_stage_reg #(.DATA_W(1), .CTRL_W(1)) dut_n (
        .Clock(Clock), .Reset_n(Reset_n), .Flush(Flush),
        .In_Valid(in_valid), .In_Ready(n_in_ready),
        .In_Ctrl(in_ctrl[0:0]), .In_Data(in_data[0:0]),
        .Out_Valid(n_out_valid), .Out_Ready(out_ready),
        .Out_Ctrl(n_out_ctrl), .Out_Data(n_out_data),
        .Occupancy(n_occ), .StallCount(n_stall)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: an ordered queue of held entries (head is presented).
    typedef struct packed {
        logic [7:0]  ctrl;
        logic [95:0] data;
    } ent_t;

    ent_t        mq[$];
    logic        m_rdy;
    logic [95:0] m_last;
    logic [15:0] m_stall;

    function automatic void model_reset();
        mq.delete();
        m_rdy   = 1'b0;
        m_last  = '0;
        m_stall = '0;
    endfunction

    function automatic void model_edge();
        ent_t e;
        bit acc;
        bit drn;
        acc = in_valid && m_rdy;
        drn = (mq.size() > 0) && out_ready;
        if ((mq.size() > 0) && !out_ready && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
        if (drn) void'(mq.pop_front());
        if (Flush) mq.delete();
        else if (acc) begin
            e.ctrl = in_ctrl;
            e.data = in_data;
            mq.push_back(e);
        end
        m_rdy = (mq.size() < 2);
        if (mq.size() > 0) m_last = mq[0].data;
    endfunction

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare both instances against the model.
    task automatic check_all(input string tag);
        logic        ov;
        logic [7:0]  ec;
        ov = (mq.size() > 0);
        ec = ov ? mq[0].ctrl : 8'h00;
        chk({tag, ".w_valid"}, 96'(w_out_valid), 96'(ov));
        chk({tag, ".w_ctrl"},  96'(w_out_ctrl),  96'(ec));
        chk({tag, ".w_data"},  w_out_data,       m_last);
        chk({tag, ".w_occ"},   96'(w_occ),       96'(mq.size()));
        chk({tag, ".w_rdy"},   96'(w_in_ready),  96'(m_rdy));
        chk({tag, ".w_stall"}, 96'(w_stall),     96'(m_stall));
        chk({tag, ".n_valid"}, 96'(n_out_valid), 96'(ov));
        chk({tag, ".n_ctrl"},  96'(n_out_ctrl),  96'(ec[0]));
        chk({tag, ".n_data"},  96'(n_out_data),  96'(m_last[0]));
        chk({tag, ".n_occ"},   96'(n_occ),       96'(mq.size()));
        chk({tag, ".n_rdy"},   96'(n_in_ready),  96'(m_rdy));
    endtask

    task automatic tick();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic step(input string tag);
        tick();
        check_all(tag);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".valid"}, 96'(w_out_valid), 96'(0));
        chk({tag, ".ctrl"},  96'(w_out_ctrl),  96'(0));
        chk({tag, ".data"},  w_out_data,       96'(0));
        chk({tag, ".occ"},   96'(w_occ),       96'(0));
        chk({tag, ".rdy"},   96'(w_in_ready),  96'(0));
        chk({tag, ".stall"}, 96'(w_stall),     96'(0));
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        Flush     = 1'b0;
        Reset_n   = 1'b0;
        #2;
        chk_reset_vals("rst_hold");
        @(negedge Clock);
        Reset_n = 1'b1;
        model_reset();
        step("rst_release");
    endtask

    typedef struct packed {
        logic        iv;
        logic        ordy;
        logic        fl;
        logic [95:0] d;
        logic        e_ov;
        logic [95:0] e_d;
        logic [1:0]  e_occ;
        logic        e_rdy;
        logic [15:0] e_stall;
    } row_t;

    function automatic row_t mk(input logic iv, input logic ordy, input logic fl,
                                input logic [95:0] d, input logic e_ov, input logic [95:0] e_d,
                                input logic [1:0] e_occ, input logic e_rdy, input logic [15:0] e_stall);
        row_t r;
        r.iv = iv; r.ordy = ordy; r.fl = fl; r.d = d;
        r.e_ov = e_ov; r.e_d = e_d; r.e_occ = e_occ; r.e_rdy = e_rdy; r.e_stall = e_stall;
        return r;
    endfunction

    row_t rows[17];

    initial begin
        // Streaming, back-pressure, flush in FULL, flush racing an accept.
        rows[0]  = mk(1, 1, 0, 96'h1, 1, 96'h1, 2'd1, 1, 16'd0);
        rows[1]  = mk(1, 1, 0, 96'h2, 1, 96'h2, 2'd1, 1, 16'd0);
        rows[2]  = mk(1, 1, 0, 96'h3, 1, 96'h3, 2'd1, 1, 16'd0);
        rows[3]  = mk(1, 1, 0, 96'h4, 1, 96'h4, 2'd1, 1, 16'd0);
        rows[4]  = mk(0, 1, 0, 96'h0, 0, 96'h4, 2'd0, 1, 16'd0);
        rows[5]  = mk(1, 0, 0, 96'hA, 1, 96'hA, 2'd1, 1, 16'd0);
        rows[6]  = mk(1, 0, 0, 96'hB, 1, 96'hA, 2'd2, 0, 16'd1);
        rows[7]  = mk(1, 0, 0, 96'hD, 1, 96'hA, 2'd2, 0, 16'd2);
        rows[8]  = mk(0, 1, 0, 96'h0, 1, 96'hB, 2'd1, 1, 16'd2);
        rows[9]  = mk(0, 1, 0, 96'h0, 0, 96'hB, 2'd0, 1, 16'd2);
        rows[10] = mk(1, 0, 0, 96'hE, 1, 96'hE, 2'd1, 1, 16'd2);
        rows[11] = mk(1, 0, 0, 96'hF, 1, 96'hE, 2'd2, 0, 16'd3);
        rows[12] = mk(1, 0, 1, 96'hC, 0, 96'hE, 2'd0, 1, 16'd4);
        rows[13] = mk(0, 1, 0, 96'h0, 0, 96'hE, 2'd0, 1, 16'd4);
        rows[14] = mk(1, 1, 1, 96'h9, 0, 96'hE, 2'd0, 1, 16'd4);
        rows[15] = mk(1, 1, 0, 96'h8, 1, 96'h8, 2'd1, 1, 16'd4);
        rows[16] = mk(0, 1, 0, 96'h0, 0, 96'h8, 2'd0, 1, 16'd4);

        in_valid  = 1'b0;
        out_ready = 1'b0;
        Flush     = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        Reset_n   = 1'b1;
        #1;
        do_reset();

        // Directed vector table.
        for (int i = 0; i < 17; i++) begin
            in_valid  = rows[i].iv;
            out_ready = rows[i].ordy;
            Flush     = rows[i].fl;
            in_data   = rows[i].d;
            in_ctrl   = 8'h40 + 8'(rows[i].d);
            tick();
            chk($sformatf("row%0d.valid", i), 96'(w_out_valid), 96'(rows[i].e_ov));
            chk($sformatf("row%0d.ctrl", i),  96'(w_out_ctrl),
                96'(rows[i].e_ov ? 8'h40 + 8'(rows[i].e_d) : 8'h00));
            chk($sformatf("row%0d.data", i),  w_out_data, rows[i].e_d);
            chk($sformatf("row%0d.occ", i),   96'(w_occ), 96'(rows[i].e_occ));
            chk($sformatf("row%0d.rdy", i),   96'(w_in_ready), 96'(rows[i].e_rdy));
            chk($sformatf("row%0d.stall", i), 96'(w_stall), 96'(rows[i].e_stall));
        end
        Flush = 1'b0;

        // StallCount saturation.
        do_reset();
        in_valid  = 1'b1;
        in_data   = 96'h55;
        in_ctrl   = 8'h55;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (65534) tick();
        chk("sat.fffe", 96'(w_stall), 96'(16'hFFFE));
        tick();
        chk("sat.ffff", 96'(w_stall), 96'(16'hFFFF));
        repeat (10) tick();
        chk("sat.hold", 96'(w_stall), 96'(16'hFFFF));
        chk("sat.data", w_out_data, 96'h55);

        // Async reset between edges while FULL.
        in_valid = 1'b1;
        in_data  = 96'h77;
        in_ctrl  = 8'h11;
        tick();
        chk("full.occ", 96'(w_occ), 96'(2));
        chk("full.rdy", 96'(w_in_ready), 96'(0));
        in_valid = 1'b0;
        @(negedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        chk_reset_vals("async");
        #1;
        Reset_n = 1'b1;
        model_reset();
        chk("async.rdy_before_edge", 96'(w_in_ready), 96'(0));
        step("async_rel");
        chk("async.rdy_after_edge", 96'(w_in_ready), 96'(1));

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            Flush     = ($urandom_range(99) < 2);
            in_ctrl   = 8'($urandom);
            in_data   = {$urandom, $urandom, $urandom};
            step($sformatf("rnd%0d", c));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        Flush     = 1'b0;
        repeat (4) step("tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have one clock, Clock, and an asynchronous, active-low reset, Reset_n.
REQ-002 Parameter DATA_W SHALL default to 96 and set the width of the datapath fields (ALU result, write data, PC).
REQ-003 Parameter CTRL_W SHALL default to 8 and set the width of the control fields (MemRead, MemWrite, RegWrite, ByteSel, MemToReg, ...).
REQ-004 Parameter CTRL_BUBBLE SHALL default to all-zero and give the control value presented whenever no valid entry is output.
REQ-005 Ports, as name  direction  width  meaning:
- Clock  in  1  rising-edge clock
- Reset_n  in  1  async active-low reset
- Flush  in  1  synchronous kill of all held and incoming entries
- In_Valid  in  1  upstream entry present
- In_Ready  out  1  stage can accept; registered
- In_Ctrl  in  CTRL_W  upstream control fields
- In_Data  in  DATA_W  upstream data fields
- Out_Valid  out  1  entry presented downstream
- Out_Ready  in  1  downstream accepts
- Out_Ctrl  out  CTRL_W  control of presented entry, or CTRL_BUBBLE
- Out_Data  out  DATA_W  data of presented entry
- Occupancy  out  2  entries held (0, 1, 2)
- StallCount  out  16  saturating count of back-pressured cycles

Function
REQ-006 Storage SHALL be two entries: a main register that drives Out_* and a skid register; both SHALL hold {ctrl, data, valid}.
REQ-007 Accept SHALL occur on a rising edge with In_Valid=1 and In_Ready=1; drain SHALL occur on a rising edge with Out_Valid=1 and Out_Ready=1.
REQ-008 In_Ready SHALL be a register output equal to 1 exactly when the skid entry is empty; it SHALL have no combinational path from Out_Ready.
REQ-009 State SHALL follow Occupancy: EMPTY(0), ONE(1), FULL(2).
REQ-010 EMPTY + accept -> ONE, with the main register loaded from In_*.
REQ-011 ONE + accept + drain -> ONE, with the main register loaded from In_*.
REQ-012 ONE + accept + no drain -> FULL, with the skid register loaded from In_*.
REQ-013 ONE + drain + no accept -> EMPTY.
REQ-014 FULL + drain -> ONE, with the main register loaded from skid; In_Ready=0 in FULL, so no accept occurs there.
REQ-015 Latency SHALL be 1 cycle: an entry accepted at edge N into an EMPTY stage SHALL show Out_Valid=1 after edge N.
REQ-016 Entries SHALL leave in acceptance order; none SHALL be dropped or duplicated except under Flush.
REQ-017 When Out_Valid=0, Out_Ctrl SHALL equal CTRL_BUBBLE; Out_Data SHALL hold its last value, with no toggling on bubbles.
REQ-018 Flush=1 at an edge SHALL take priority over everything else, with the following result:
- both valid bits cleared; Occupancy=0; Out_Ctrl=CTRL_BUBBLE; In_Ready=1;
- any same-cycle accept discarded; a same-cycle drain still counts as delivered downstream.
REQ-019 StallCount SHALL increment by 1 on each edge where Out_Valid=1 and Out_Ready=0, and SHALL saturate at 16'hFFFF (no wrap).
REQ-020 Flush SHALL NOT affect StallCount.

Reset
REQ-021 While Reset_n=0, regardless of Clock, the outputs SHALL be:
- Out_Valid=0, Out_Ctrl=CTRL_BUBBLE, Out_Data=0, Occupancy=0, In_Ready=0, StallCount=0;
- skid entry cleared.
REQ-022 In_Ready SHALL rise to 1 at the first rising edge after Reset_n deasserts.
REQ-023 Reset_n asserted mid-transfer SHALL discard all entries immediately, with no partial update.

Verification
REQ-024 Streaming: Out_Ready=1, In_Valid=1 for 4 cycles with In_Data=1,2,3,4 -> Out_Data=1,2,3,4 on consecutive cycles one edge later; Occupancy stays 1; StallCount=0.
REQ-025 Back-pressure: accept A=0xA, then hold Out_Ready=0 and offer B=0xB -> Occupancy=2, In_Ready=0, and B is held. Raise Out_Ready -> A then B out on consecutive cycles, then Occupancy=0.
REQ-026 Flush in FULL with In_Valid=1 (C=0xC) -> next cycle Out_Valid=0, Out_Ctrl=CTRL_BUBBLE, Occupancy=0, In_Ready=1; C never appears at the output.
REQ-027 Saturation: Out_Valid=1, Out_Ready=0 for 70000 cycles -> StallCount=0xFFFF and holds.
REQ-028 Async reset: pulse Reset_n low between clock edges while FULL -> outputs reach their reset values before the next edge; In_Ready=1 one edge after release.
REQ-029 Random stimulus with a scoreboard, Flush at 2% and all parameters at default plus DATA_W=1 and CTRL_W=1 -> output order matches acceptance order, with no loss outside Flush.
